mem_lsu: RTL and testbench

MEM-stage load/store unit sitting directly upstream of the write-back stage. It takes one memory operation per instruction from the EX/MEM register and runs it on a split-transaction data bus with request/address-accept/data-return phases. It stalls the pipeline until the access completes and hands the raw 32-bit read word to WB. WB performs the byte/half extraction and sign extension. Misaligned accesses are detected here and reported as exceptions without touching the bus.

---
 rtl/mem_lsu_pkg.sv | 30 +++
 rtl/mem_lsu_store_align.sv | 51 +++++
 rtl/mem_lsu.sv | 181 ++++++++++++++++++
 tb/tb_mem_lsu.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_lsu_pkg.sv
// ----------------------------------------------------------------------------
// mem_lsu_pkg
// Shared encodings for the MEM-stage load/store unit:
//   - mem_sel byte-enable patterns coming from the EX/MEM register
//   - data_size encodings driven onto the split-transaction data bus
//   - FSM state type used by mem_lsu
// ----------------------------------------------------------------------------
package mem_lsu_pkg;

    // Right-aligned byte-enable patterns describing the access width
    localparam logic [3:0] SEL_BYTE = 4'b0001;
    localparam logic [3:0] SEL_HALF = 4'b0011;
    localparam logic [3:0] SEL_WORD = 4'b1111;

    // Bus transfer size encodings
    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    // Access sequencing: request phase, wait for data, one-cycle release,
    // and a drain state that retires a transaction orphaned by a flush
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_DONE,
        ST_DRAIN
    } lsu_state_e;

endpackage

// File: rtl/mem_lsu_store_align.sv
// ----------------------------------------------------------------------------
// store_align
// Purely combinational mapping from the access width and low address bits to
// the bus-side transfer description.
// Ports:
//   sel_i       in   4   access width as byte-enable pattern (byte/half/word)
//   addr_lo_i   in   2   effective address bits [1:0]
//   wdata_i     in  32   right-aligned store data
//   size_o      out  2   bus transfer size
//   wstrb_o     out  4   byte lanes touched by the access
//   wdata_o     out 32   store data replicated across all lanes
//   misalign_o  out  1   access not naturally aligned
// ----------------------------------------------------------------------------
module store_align
    import mem_lsu_pkg::*;
(
    input  logic [3:0]  sel_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] wdata_i,
    output logic [1:0]  size_o,
    output logic [3:0]  wstrb_o,
    output logic [31:0] wdata_o,
    output logic        misalign_o
);

    // Replicating the data into every lane lets the slave pick whichever
    // lane the strobe selects without needing a shifter of its own.
    // Any unrecognised sel pattern is treated as a full word.
    always_comb begin
        size_o     = SIZE_WORD;
        wstrb_o    = 4'b1111;
        wdata_o    = wdata_i;
        misalign_o = (addr_lo_i != 2'b00);
        case (sel_i)
            SEL_BYTE: begin
                size_o     = SIZE_BYTE;
                wstrb_o    = 4'b0001 << addr_lo_i;
                wdata_o    = {4{wdata_i[7:0]}};
                misalign_o = 1'b0;
            end
            SEL_HALF: begin
                size_o     = SIZE_HALF;
                wstrb_o    = 4'b0011 << addr_lo_i;
                wdata_o    = {2{wdata_i[15:0]}};
                misalign_o = addr_lo_i[0];
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_lsu.sv
// ----------------------------------------------------------------------------
// mem_lsu
// MEM-stage load/store unit. Runs one load or store per instruction on a
// split-transaction data bus (request / address accept / data return),
// stalls the pipeline until the access retires and hands the raw read word
// to write-back. Misaligned accesses raise an address error instead of
// touching the bus.
// Ports:
//   clk, rst                 clock and synchronous active-high reset
//   flush_i                  exception/eret flush, kills the current op
//   mem_read_flag_i          load in MEM
//   mem_write_flag_i         store in MEM
//   mem_sel_i                access width (0001 byte, 0011 half, 1111 word)
//   addr_i                   effective address
//   mem_write_data_i         right-aligned store data
//   data_req .. data_wdata   bus request phase outputs
//   data_addr_ok             bus accepted the request
//   data_data_ok             read data valid / write complete
//   data_rdata               read word from the bus
//   stall_req_o              hold IF..MEM while the access is in flight
//   ram_read_data_o          latched raw read word for WB
//   adel_o, ades_o           load / store address error
//   bad_vaddr_o              faulting address when an error flag is set
// ----------------------------------------------------------------------------
module mem_lsu
    import mem_lsu_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush_i,
    input  logic              mem_read_flag_i,
    input  logic              mem_write_flag_i,
    input  logic [3:0]        mem_sel_i,
    input  logic [DATA_W-1:0] addr_i,
    input  logic [DATA_W-1:0] mem_write_data_i,
    output logic              data_req,
    output logic              data_wr,
    output logic [1:0]        data_size,
    output logic [DATA_W-1:0] data_addr,
    output logic [3:0]        data_wstrb,
    output logic [DATA_W-1:0] data_wdata,
    input  logic              data_addr_ok,
    input  logic              data_data_ok,
    input  logic [DATA_W-1:0] data_rdata,
    output logic              stall_req_o,
    output logic [DATA_W-1:0] ram_read_data_o,
    output logic              adel_o,
    output logic              ades_o,
    output logic [DATA_W-1:0] bad_vaddr_o
);

    lsu_state_e        state_q, state_d;
    logic              is_read_q, is_read_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;

    logic              op;
    logic              misalign;
    logic [1:0]        al_size;
    logic [3:0]        al_wstrb;
    logic [DATA_W-1:0] al_wdata;

    assign op = mem_read_flag_i | mem_write_flag_i;

    store_align u_store_align (
        .sel_i      (mem_sel_i),
        .addr_lo_i  (addr_i[1:0]),
        .wdata_i    (mem_write_data_i),
        .size_o     (al_size),
        .wstrb_o    (al_wstrb),
        .wdata_o    (al_wdata),
        .misalign_o (misalign)
    );

    // Address errors come straight from the inputs so the exception is seen
    // in the same cycle as the offending instruction; a flush means the
    // instruction is already dead and must not raise anything.
    always_comb begin
        adel_o      = !rst && !flush_i && mem_read_flag_i  && misalign;
        ades_o      = !rst && !flush_i && mem_write_flag_i && misalign;
        bad_vaddr_o = (adel_o || ades_o) ? addr_i : '0;
    end

    // Next-state and bus outputs. The stall is raised already in IDLE when a
    // valid access shows up so the instruction is frozen in MEM from its
    // first cycle; DONE drops it for exactly one cycle to let it advance.
    // The read/write kind is captured while the request is presented because
    // a flush may change the inputs before the data returns.
    always_comb begin
        state_d     = state_q;
        is_read_d   = is_read_q;
        rdata_d     = rdata_q;
        data_req    = 1'b0;
        data_wr     = 1'b0;
        data_size   = SIZE_BYTE;
        data_addr   = '0;
        data_wstrb  = 4'b0000;
        data_wdata  = '0;
        stall_req_o = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (op && !misalign && !flush_i) begin
                    stall_req_o = 1'b1;
                    state_d     = ST_REQ;
                end
            end
            ST_REQ: begin
                stall_req_o = 1'b1;
                data_req    = 1'b1;
                data_wr     = mem_write_flag_i;
                data_size   = al_size;
                data_addr   = addr_i;
                data_wstrb  = mem_write_flag_i ? al_wstrb : 4'b0000;
                data_wdata  = al_wdata;
                is_read_d   = mem_read_flag_i;
                if (data_addr_ok) begin
                    state_d = flush_i ? ST_DRAIN : ST_WAIT;
                end else if (flush_i) begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                stall_req_o = 1'b1;
                if (data_data_ok) begin
                    if (flush_i) begin
                        state_d = ST_IDLE;
                    end else begin
                        if (is_read_q) begin
                            rdata_d = data_rdata;
                        end
                        state_d = ST_DONE;
                    end
                end else if (flush_i) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            ST_DRAIN: begin
                stall_req_o = 1'b1;
                if (data_data_ok) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // While reset is held every output reads as zero, even though the
        // state register only clears on the next edge.
        if (rst) begin
            data_req    = 1'b0;
            data_wr     = 1'b0;
            data_size   = SIZE_BYTE;
            data_addr   = '0;
            data_wstrb  = 4'b0000;
            data_wdata  = '0;
            stall_req_o = 1'b0;
        end
    end

    assign ram_read_data_o = rdata_q;

    // State, captured access kind and the read latch
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            is_read_q <= 1'b0;
            rdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            is_read_q <= is_read_d;
            rdata_q   <= rdata_d;
        end
    end

endmodule

// File: tb/tb_mem_lsu.sv
// ----------------------------------------------------------------------------
// tb_mem_lsu
// Self-checking bench for mem_lsu. A driver plays the EX/MEM register and a
// bus slave with fixed address/data latencies; a single checker process
// compares the DUT every cycle against a transaction-level model and a few
// hand-computed literal values.
// ----------------------------------------------------------------------------
module tb_mem_lsu;

    logic        clk;
    logic        rst;
    logic        flush_i;
    logic        mem_read_flag_i;
    logic        mem_write_flag_i;
    logic [3:0]  mem_sel_i;
    logic [31:0] addr_i;
    logic [31:0] mem_write_data_i;
    logic        data_req;
    logic        data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr;
    logic [3:0]  data_wstrb;
    logic [31:0] data_wdata;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic [31:0] data_rdata;
    logic        stall_req_o;
    logic [31:0] ram_read_data_o;
    logic        adel_o;
    logic        ades_o;
    logic [31:0] bad_vaddr_o;

    mem_lsu #(.DATA_W(32)) dut (
        .clk              (clk),
        .rst              (rst),
        .flush_i          (flush_i),
        .mem_read_flag_i  (mem_read_flag_i),
        .mem_write_flag_i (mem_write_flag_i),
        .mem_sel_i        (mem_sel_i),
        .addr_i           (addr_i),
        .mem_write_data_i (mem_write_data_i),
        .data_req         (data_req),
        .data_wr          (data_wr),
        .data_size        (data_size),
        .data_addr        (data_addr),
        .data_wstrb       (data_wstrb),
        .data_wdata       (data_wdata),
        .data_addr_ok     (data_addr_ok),
        .data_data_ok     (data_data_ok),
        .data_rdata       (data_rdata),
        .stall_req_o      (stall_req_o),
        .ram_read_data_o  (ram_read_data_o),
        .adel_o           (adel_o),
        .ades_o           (ades_o),
        .bad_vaddr_o      (bad_vaddr_o)
    );

    // Clock: 10 time-unit period, inputs change #1 after rising edges and
    // outputs are sampled on falling edges
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Check mode: 0 idle, 1 modelled transaction, 2 directed scenario, 3 none
    int          mode;
    int          tid;
    int          k;
    logic        t_rd;
    logic        t_wr;
    logic [3:0]  t_sel;
    logic [31:0] t_addr;
    logic [31:0] t_wd;
    int          t_alat;
    int          t_dlat;
    logic [31:0] t_rdata;

    int          tests;
    int          fails;
    logic [31:0] exp_ram;
    int          scnt;

    // Compare helper, only used by the checker process
    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h (tid %0d cycle %0d)", name, act, exp, tid, k);
        end
    endtask

    // Checker: one process owns every counter and the model state
    initial begin
        int          nb;
        logic        mis;
        logic        exp_stall;
        logic        exp_req;
        logic [3:0]  exp_wstrb;
        logic [31:0] exp_wdata;
        tests   = 0;
        fails   = 0;
        exp_ram = 32'h0;
        scnt    = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                exp_ram = 32'h0;
            end
            if (mode == 1) begin
                nb  = (t_sel == 4'b0001) ? 1 : (t_sel == 4'b0011) ? 2 : 4;
                mis = (int'(t_addr[1:0]) % nb) != 0;
                exp_stall = 1'b0;
                exp_req   = 1'b0;
                if (!mis) begin
                    exp_stall = (k <= 1 + t_alat + t_dlat);
                    exp_req   = (k >= 1) && (k <= 1 + t_alat);
                    if (k == 2 + t_alat + t_dlat && t_rd) begin
                        exp_ram = t_rdata;
                    end
                end
                if (k == 0) begin
                    scnt = 0;
                end
                if (stall_req_o) begin
                    scnt++;
                end
                checkOutput("stall", stall_req_o, exp_stall);
                checkOutput("req", data_req, exp_req);
                checkOutput("ram", ram_read_data_o, exp_ram);
                checkOutput("adel", adel_o, t_rd && mis);
                checkOutput("ades", ades_o, t_wr && mis);
                checkOutput("badva", bad_vaddr_o, mis ? t_addr : 32'h0);
                if (exp_req) begin
                    exp_wstrb = t_wr ? 4'((((1 << nb) - 1)) << t_addr[1:0]) : 4'h0;
                    exp_wdata = (nb == 1) ? t_wd[7:0] * 32'h01010101 :
                                (nb == 2) ? t_wd[15:0] * 32'h00010001 : t_wd;
                    checkOutput("wr", data_wr, t_wr);
                    checkOutput("size", data_size, (nb == 1) ? 0 : (nb == 2) ? 1 : 2);
                    checkOutput("addr", data_addr, t_addr);
                    checkOutput("wstrb", data_wstrb, exp_wstrb);
                    if (t_wr) begin
                        checkOutput("wdata", data_wdata, exp_wdata);
                    end
                end
                // Hand-computed pins on the model
                if (tid == 1 && k == 3) begin
                    checkOutput("pin_stall_cycles", scnt, 3);
                    checkOutput("pin_load_word", ram_read_data_o, 32'hDEADBEEF);
                end
                if (tid == 2 && k == 1) begin
                    checkOutput("pin_sb_wstrb", data_wstrb, 32'h8);
                    checkOutput("pin_sb_wdata", data_wdata, 32'hA5A5A5A5);
                    checkOutput("pin_sb_size", data_size, 0);
                    checkOutput("pin_sb_wr", data_wr, 1);
                end
                if (tid == 3) begin
                    checkOutput("pin_lh_adel", adel_o, 1);
                    checkOutput("pin_lh_badva", bad_vaddr_o, 32'h80000301);
                end
                if (tid == 4) begin
                    checkOutput("pin_sw_ades", ades_o, 1);
                end
            end else if (mode == 2) begin
                case (tid)
                    10: begin
                        checkOutput("fl_stall", stall_req_o, (k <= 6) ? 1 : 0);
                        checkOutput("fl_req", data_req, (k == 1) ? 1 : 0);
                        if (k == 7) begin
                            checkOutput("fl_ram_kept", ram_read_data_o, 32'hDEADBEEF);
                        end
                    end
                    11: begin
                        checkOutput("fi_stall", stall_req_o, 0);
                        checkOutput("fi_req", data_req, 0);
                    end
                    12: begin
                        checkOutput("fm_adel", adel_o, 0);
                        checkOutput("fm_badva", bad_vaddr_o, 0);
                        checkOutput("fm_stall", stall_req_o, 0);
                    end
                    13: begin
                        if (k == 0) checkOutput("rr_stall0", stall_req_o, 1);
                        if (k == 1) checkOutput("rr_req1", data_req, 1);
                        if (k == 2) begin
                            checkOutput("rr_req", data_req, 0);
                            checkOutput("rr_stall", stall_req_o, 0);
                            checkOutput("rr_ram", ram_read_data_o, 0);
                            checkOutput("rr_addr", data_addr, 0);
                            checkOutput("rr_wstrb", data_wstrb, 0);
                            checkOutput("rr_adel", adel_o, 0);
                        end
                    end
                    20: begin
                        checkOutput("rst_req", data_req, 0);
                        checkOutput("rst_stall", stall_req_o, 0);
                        checkOutput("rst_ram", ram_read_data_o, 0);
                        checkOutput("rst_adel", adel_o, 0);
                        checkOutput("rst_ades", ades_o, 0);
                        checkOutput("rst_badva", bad_vaddr_o, 0);
                    end
                    default: ;
                endcase
            end else if (mode == 0) begin
                checkOutput("idle_req", data_req, 0);
                checkOutput("idle_stall", stall_req_o, 0);
                checkOutput("idle_ram", ram_read_data_o, exp_ram);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clearOps();
        mem_read_flag_i  = 1'b0;
        mem_write_flag_i = 1'b0;
        mem_sel_i        = 4'b0000;
        addr_i           = 32'h0;
        mem_write_data_i = 32'h0;
        flush_i          = 1'b0;
        data_addr_ok     = 1'b0;
        data_data_ok     = 1'b0;
        data_rdata       = 32'h0;
    endtask

    // One instruction in MEM with a bus slave answering after a_lat cycles
    // of request and d_lat cycles of wait (d_lat >= 1)
    task automatic applyStimulus(input int id, input logic rd, input logic wr,
                                 input logic [3:0] sel, input logic [31:0] addr,
                                 input logic [31:0] wd, input int a_lat,
                                 input int d_lat, input logic [31:0] rdv);
        int   nb;
        int   len;
        logic mis;
        nb  = (sel == 4'b0001) ? 1 : (sel == 4'b0011) ? 2 : 4;
        mis = (int'(addr[1:0]) % nb) != 0;
        len = mis ? 1 : 3 + a_lat + d_lat;
        t_rd = rd; t_wr = wr; t_sel = sel; t_addr = addr; t_wd = wd;
        t_alat = a_lat; t_dlat = d_lat; t_rdata = rdv;
        tid  = id;
        mode = 1;
        mem_read_flag_i  = rd;
        mem_write_flag_i = wr;
        mem_sel_i        = sel;
        addr_i           = addr;
        mem_write_data_i = wd;
        for (int i = 0; i < len; i++) begin
            k            = i;
            data_addr_ok = !mis && (i == 1 + a_lat);
            data_data_ok = !mis && (i == 1 + a_lat + d_lat);
            data_rdata   = data_data_ok ? rdv : $urandom;
            step();
        end
        mode = 0;
        clearOps();
        step();
    endtask

    initial begin
        mode = 3;
        tid  = 0;
        k    = 0;
        t_rd = 0; t_wr = 0; t_sel = 0; t_addr = 0; t_wd = 0;
        t_alat = 0; t_dlat = 0; t_rdata = 0;
        rst = 1'b1;
        clearOps();
        repeat (2) @(posedge clk);
        #1;
        tid  = 20;
        mode = 2;
        step();
        mode = 3;
        rst  = 1'b0;
        step();
        mode = 0;
        step();

        applyStimulus(1, 1, 0, 4'b1111, 32'h80000104, 32'h0, 0, 1, 32'hDEADBEEF);

        // Flush while waiting for data: drain, discard, keep the latch
        tid = 10; mode = 2;
        k = 0; mem_read_flag_i = 1; mem_sel_i = 4'b1111; addr_i = 32'h80000500; step();
        k = 1; data_addr_ok = 1; step();
        k = 2; data_addr_ok = 0; flush_i = 1; step();
        k = 3; flush_i = 0; mem_read_flag_i = 0; step();
        k = 4; step();
        k = 5; step();
        k = 6; data_data_ok = 1; data_rdata = 32'h12345678; step();
        k = 7; data_data_ok = 0; data_rdata = 32'h0; step();
        mode = 0; clearOps(); step();

        applyStimulus(2, 0, 1, 4'b0001, 32'h80000203, 32'h000000A5, 1, 2, 32'h0);
        applyStimulus(3, 1, 0, 4'b0011, 32'h80000301, 32'h0, 0, 1, 32'h0);
        applyStimulus(4, 0, 1, 4'b1111, 32'h80000402, 32'h11223344, 0, 1, 32'h0);

        // Flush on an aligned op in IDLE: nothing starts
        tid = 11; mode = 2; k = 0;
        mem_read_flag_i = 1; mem_sel_i = 4'b1111; addr_i = 32'h80000540; flush_i = 1;
        step();
        mode = 0; clearOps(); step();

        // Flush on a misaligned op: error suppressed
        tid = 12; mode = 2; k = 0;
        mem_read_flag_i = 1; mem_sel_i = 4'b0011; addr_i = 32'h80000551; flush_i = 1;
        step();
        mode = 0; clearOps(); step();

        applyStimulus(5, 0, 1, 4'b0011, 32'h80000406, 32'h0000BEEF, 2, 3, 32'h0);
        applyStimulus(6, 1, 0, 4'b0011, 32'h80000402, 32'h0, 0, 1, 32'hCAFEF00D);
        applyStimulus(7, 1, 0, 4'b0001, 32'h80000701, 32'h0, 1, 1, 32'h000000AB);
        applyStimulus(8, 0, 1, 4'b1111, 32'h80000800, 32'h55AA33CC, 0, 2, 32'h0);
        applyStimulus(9, 0, 1, 4'b0011, 32'h80000803, 32'h00001234, 0, 1, 32'h0);
        applyStimulus(14, 1, 0, 4'b0001, 32'h80000902, 32'h0, 3, 4, 32'h77665544);

        // Reset while the request is pending
        tid = 13; mode = 2;
        k = 0; mem_read_flag_i = 1; mem_sel_i = 4'b1111; addr_i = 32'h80000600; step();
        k = 1;
        @(negedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        k = 2; step();
        mode = 3; rst = 1'b0; clearOps(); step();
        mode = 0; step();

        applyStimulus(15, 1, 0, 4'b1111, 32'h80000A00, 32'h0, 0, 1, 32'h89ABCDEF);

        mode = 3;
        @(negedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
